// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan -- eight-digit multiplexed seven-segment display driver
//
// Purpose:
//   Lights one digit at a time for CLK_DIV clock cycles and walks the digit
//   index 0..7. Data is double-buffered:
//   - a load strobe captures data into a hold register;
//   - the hold register is copied to the displayed shadow register only at a
//     frame boundary (index 7 slot ending), so a frame never mixes values.
//   Outputs an/a2g are registered, giving one cycle of latency.
//
// Optional feature:
//   Define SEG7_SCAN_LZ_BLANK_EN to blank leading-zero digits. Digit 0 is
//   never blanked. Scan timing, frame_done and commit behaviour are the same
//   in both builds.
//
// Parameters:
//   CLK_DIV     clock cycles each digit is lit (2 .. 2^20)
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset
//   load        in   1   single-cycle strobe, capture data into hold
//   data        in   32  eight hex nibbles, nibble k -> digit k
//   an          out  8   digit anodes, active-low (one low or all high)
//   a2g         out  7   segments a..g, active-low, a2g[6]=a
//   pending     out  1   captured data waits for the next frame boundary
//   frame_done  out  1   one-cycle pulse in the last cycle of digit 7's slot
// ---------------------------------------------------------------------------
module seg7_scan #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data,
  output logic [7:0]  an,
  output logic [6:0]  a2g,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned        DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       a2g_q, a2g_d;

  logic             div_wrap;
  logic             frame_end;
  logic             commit;
  logic [31:0]      shadow_shr;

  // Active-low abcdefg pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  always_comb begin
    div_wrap   = (div_q == DIV_LAST);
    frame_end  = div_wrap && (idx_q == 3'd7);
    commit     = frame_end && pending_q;

    div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d      = div_wrap ? idx_q + 3'd1 : idx_q;

    hold_d     = hold_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;

    // Commit reads the old hold before a coincident load replaces it, and
    // the load then leaves pending set for the following frame.
    if (commit) begin
      shadow_d  = hold_q;
      pending_d = 1'b0;
    end
    if (load) begin
      hold_d    = data;
      pending_d = 1'b1;
    end

    // Shadow shifted so the current digit's nibble sits in bits 3:0; the
    // remaining upper bits are the more-significant digits.
    shadow_shr = shadow_q >> {idx_q, 2'b00};
    an_d       = ~(8'b1 << idx_q);
    a2g_d      = seg_decode(shadow_shr[3:0]);

`ifdef SEG7_SCAN_LZ_BLANK_EN
    if ((idx_q != 3'd0) && (shadow_shr == 32'd0)) begin
      an_d  = 8'hFF;
      a2g_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= 3'd0;
      hold_q    <= 32'd0;
      shadow_q  <= 32'd0;
      pending_q <= 1'b0;
      an_q      <= 8'hFF;
      a2g_q     <= 7'h7F;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      a2g_q     <= a2g_d;
    end
  end

  assign an         = an_q;
  assign a2g        = a2g_q;
  assign pending    = pending_q;
  // Decoded from registered state; gated so it stays low while reset is held.
  assign frame_done = frame_end && !reset;

endmodule
